// File: rtl/riscv_pipe_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Control bundles are packed as {enPc, enIf, enId, enEx, enMem, flushIf, inhibitControl, flushEx}.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_WAIT  = 2'd2
    } stall_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic enPc;
        logic enIf;
        logic enId;
        logic enEx;
        logic enMem;
        logic flushIf;
        logic inhibitControl;
        logic flushEx;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN     = stage_ctrl_t'(8'b11111_000);
    localparam stage_ctrl_t CTRL_FREEZE  = stage_ctrl_t'(8'b00000_000);
    localparam stage_ctrl_t CTRL_MD      = stage_ctrl_t'(8'b00001_001);
    localparam stage_ctrl_t CTRL_BRANCH  = stage_ctrl_t'(8'b11111_110);
    localparam stage_ctrl_t CTRL_LOADUSE = stage_ctrl_t'(8'b00111_010);

    // Non-memory hazard priority: mul/div hold, then taken branch, then load-use.
    function automatic stage_ctrl_t applyRules(input logic mdStall,
                                               input logic branch,
                                               input logic loadUse);
        stage_ctrl_t r;
        r = CTRL_RUN;
        if (mdStall)      r = CTRL_MD;
        else if (branch)  r = CTRL_BRANCH;
        else if (loadUse) r = CTRL_LOADUSE;
        return r;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: one FSM decides every
// stage enable and bubble so coincident hazards have a single outcome.
module pipeline_stall_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exMemRead,
    input  logic [4:0]       exRd,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic             idUsesRs1,
    input  logic             idUsesRs2,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             mdStart,
    input  logic             mdDone,
    output logic             en_pc,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             flush_if,
    output logic             inhibitControl,
    output logic             flush_ex,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushEvents,
    output logic [1:0]       stateDbg
);

    stall_state_t state, nextState;
    stage_ctrl_t  ctrl;
    logic [15:0]  toCnt;
    logic         loadUse, memStall, mdStall;

    assign loadUse  = exMemRead && (exRd != REG_ZERO) &&
                      ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
    assign memStall = memReq && !memReady;
    assign mdStall  = mdStart && !mdDone;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            toCnt      <= '0;
            memTimeout <= 1'b0;
        end else begin
            state <= nextState;
            // The timeout only watches cycles spent frozen in MEM_WAIT; it never aborts the wait.
            if ((state == MEM_WAIT) && !memReady) begin
                if (toCnt != 16'hFFFF) toCnt <= toCnt + 16'd1;
                if (({1'b0, toCnt} + 17'd1) >= 17'(MEM_TIMEOUT)) memTimeout <= 1'b1;
            end else begin
                toCnt <= '0;
            end
        end
    end

    always_comb begin
        ctrl      = CTRL_RUN;
        nextState = state;
        unique case (state)
            RUN: begin
                if (memStall) begin
                    ctrl      = CTRL_FREEZE;
                    nextState = MEM_WAIT;
                end else begin
                    ctrl      = applyRules(mdStall, branchTaken, loadUse);
                    nextState = mdStall ? MD_WAIT : RUN;
                end
            end
            MEM_WAIT: begin
                if (!memReady) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl      = applyRules(mdStall, branchTaken, loadUse);
                    nextState = mdStall ? MD_WAIT : RUN;
                end
            end
            MD_WAIT: begin
                // A memory wait freezes the whole pipe, including the MEM/WB drain.
                if (memStall) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl      = applyRules(!mdDone, branchTaken, loadUse);
                    nextState = mdDone ? RUN : MD_WAIT;
                end
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    assign en_pc          = ctrl.enPc;
    assign en_if          = ctrl.enIf;
    assign en_id          = ctrl.enId;
    assign en_ex          = ctrl.enEx;
    assign en_mem         = ctrl.enMem;
    assign flush_if       = ctrl.flushIf;
    assign inhibitControl = ctrl.inhibitControl;
    assign flush_ex       = ctrl.flushEx;
    assign stateDbg       = state;

    sat_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (!ctrl.enPc),
        .q     (stallCycles)
    );

    sat_counter #(.W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (ctrl.flushIf),
        .q     (flushEvents)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with hand-computed expectations; narrow counters
// (CNT_W=4) so saturation is reached within the mul/div scenario.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 4;

    // Expected control bundles: {en_pc,en_if,en_id,en_ex,en_mem,flush_if,inhibitControl,flush_ex}
    localparam logic [7:0] E_RUN    = 8'b11111_000;
    localparam logic [7:0] E_FREEZE = 8'b00000_000;
    localparam logic [7:0] E_MD     = 8'b00001_001;
    localparam logic [7:0] E_BRANCH = 8'b11111_110;
    localparam logic [7:0] E_LU     = 8'b00111_010;

    logic clk = 1'b0;
    logic rst_n;
    logic exMemRead, idUsesRs1, idUsesRs2, branchTaken, memReq, memReady, mdStart, mdDone;
    logic [4:0] exRd, idRs1, idRs2;
    logic en_pc, en_if, en_id, en_ex, en_mem, flush_if, inhibitControl, flush_ex, memTimeout;
    logic [CNT_W-1:0] stallCycles, flushEvents;
    logic [1:0] stateDbg;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .exMemRead(exMemRead), .exRd(exRd), .idRs1(idRs1), .idRs2(idRs2),
        .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2), .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady), .mdStart(mdStart), .mdDone(mdDone),
        .en_pc(en_pc), .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem),
        .flush_if(flush_if), .inhibitControl(inhibitControl), .flush_ex(flush_ex),
        .memTimeout(memTimeout), .stallCycles(stallCycles), .flushEvents(flushEvents),
        .stateDbg(stateDbg)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCtrl(input string tag, input logic [7:0] exp);
        #1;
        checkVal(tag, {24'd0, en_pc, en_if, en_id, en_ex, en_mem, flush_if, inhibitControl, flush_ex},
                 {24'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        exMemRead = 0; exRd = 0; idRs1 = 0; idRs2 = 0; idUsesRs1 = 0; idUsesRs2 = 0;
        branchTaken = 0; memReq = 0; memReady = 0; mdStart = 0; mdDone = 0;
    endtask

    task automatic setLoadUse(input logic [4:0] rd, input logic [4:0] rs1, input logic use1,
                              input logic [4:0] rs2, input logic use2);
        exMemRead = 1; exRd = rd; idRs1 = rs1; idUsesRs1 = use1; idRs2 = rs2; idUsesRs2 = use2;
    endtask

    initial begin
        setIdle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;

        // Reset state
        checkCtrl("reset_ctrl", E_RUN);
        checkVal("reset_state", {30'd0, stateDbg}, 32'd0);
        checkVal("reset_stall", {28'd0, stallCycles}, 32'd0);
        checkVal("reset_flush", {28'd0, flushEvents}, 32'd0);
        checkVal("reset_timeout", {31'd0, memTimeout}, 32'd0);

        // Load-use via rs1: one bubble
        setLoadUse(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        checkCtrl("lu_rs1", E_LU);
        tick();
        setIdle();
        checkCtrl("lu_release", E_RUN);
        checkVal("lu_stall_cnt", {28'd0, stallCycles}, 32'd1);

        // x0 never hazards
        setLoadUse(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        checkCtrl("lu_x0", E_RUN);
        tick();
        // rs2 match only counts when rs2 is used
        setLoadUse(5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        checkCtrl("lu_rs2_unused", E_RUN);
        setLoadUse(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        checkCtrl("lu_rs2", E_LU);
        tick();
        setIdle();
        checkVal("lu_stall_cnt2", {28'd0, stallCycles}, 32'd2);

        // Branch outranks load-use
        setLoadUse(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        branchTaken = 1;
        checkCtrl("br_lu", E_BRANCH);
        tick();
        setIdle();
        checkVal("br_flush_cnt", {28'd0, flushEvents}, 32'd1);
        checkVal("br_stall_cnt", {28'd0, stallCycles}, 32'd2);

        // Memory wait: 3 frozen cycles then release
        memReq = 1; memReady = 0;
        for (int i = 0; i < 3; i++) begin
            checkCtrl($sformatf("mem_freeze_%0d", i), E_FREEZE);
            tick();
            checkVal($sformatf("mem_state_%0d", i), {30'd0, stateDbg}, 32'd1);
        end
        memReady = 1;
        checkCtrl("mem_release", E_RUN);
        tick();
        setIdle();
        checkVal("mem_state_run", {30'd0, stateDbg}, 32'd0);
        checkVal("mem_stall_cnt", {28'd0, stallCycles}, 32'd5);
        checkVal("mem_no_timeout", {31'd0, memTimeout}, 32'd0);

        // Timeout: 1 RUN cycle + 5 MEM_WAIT cycles frozen; flag rises after the 4th MEM_WAIT cycle
        memReq = 1; memReady = 0;
        for (int i = 1; i <= 6; i++) begin
            checkCtrl($sformatf("to_freeze_%0d", i), E_FREEZE);
            tick();
            checkVal($sformatf("to_flag_%0d", i), {31'd0, memTimeout}, (i >= 5) ? 32'd1 : 32'd0);
        end
        memReady = 1;
        checkCtrl("to_release", E_RUN);
        tick();
        setIdle();
        checkVal("to_state_run", {30'd0, stateDbg}, 32'd0);
        checkVal("to_sticky", {31'd0, memTimeout}, 32'd1);
        checkVal("to_stall_cnt", {28'd0, stallCycles}, 32'd11);

        // Mul/div: 5 held cycles (3rd frozen by a memory stall), release with a branch
        mdStart = 1; mdDone = 0;
        for (int i = 1; i <= 5; i++) begin
            memReq = (i == 3); memReady = 0;
            branchTaken = (i == 2);
            checkCtrl($sformatf("md_hold_%0d", i), (i == 3) ? E_FREEZE : E_MD);
            tick();
            checkVal($sformatf("md_state_%0d", i), {30'd0, stateDbg}, 32'd2);
            checkVal($sformatf("md_stall_cnt_%0d", i), {28'd0, stallCycles},
                     (i >= 4) ? 32'd15 : 32'(11 + i));
        end
        memReq = 0; branchTaken = 1; mdDone = 1;
        checkCtrl("md_release_branch", E_BRANCH);
        tick();
        setIdle();
        checkVal("md_state_run", {30'd0, stateDbg}, 32'd0);
        checkVal("md_flush_cnt", {28'd0, flushEvents}, 32'd2);
        checkVal("md_stall_sat", {28'd0, stallCycles}, 32'd15);

        // Reset in the middle of MD_WAIT
        mdStart = 1; mdDone = 0;
        tick();
        checkVal("rst_pre_state", {30'd0, stateDbg}, 32'd2);
        rst_n = 0;
        tick();
        rst_n = 1;
        setIdle();
        checkVal("rst_state", {30'd0, stateDbg}, 32'd0);
        checkVal("rst_stall", {28'd0, stallCycles}, 32'd0);
        checkVal("rst_flush", {28'd0, flushEvents}, 32'd0);
        checkVal("rst_timeout", {31'd0, memTimeout}, 32'd0);
        checkCtrl("rst_ctrl", E_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
